// File: rtl/led_matrix_pkg.sv
// ============================================================================
//  Module      : led_matrix_pkg
//  Description : Shared geometry defaults, loader state encoding and a width
//                helper for the LED matrix frame loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_matrix_pkg;

   localparam int c_NCOLS_DEFAULT  = 8;
   localparam int c_NROWS_DEFAULT  = 8;
   localparam int c_FRAME_BITS_DEFAULT = c_NCOLS_DEFAULT * c_NROWS_DEFAULT;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_frame_loader_if.sv
// ============================================================================
//  Module      : led_frame_loader_if
//  Description : Valid/ready column-byte stream feeding the frame loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_frame_loader_if #(
   parameter int NROWS = 8
);
   logic [NROWS-1:0] in_data;
   logic             in_valid;
   logic             in_sof;
   logic             in_ready;

   modport master (output in_data, output in_valid, output in_sof, input in_ready);
   modport slave  (input in_data, input in_valid, input in_sof, output in_ready);
endinterface

`default_nettype wire

// File: rtl/led_frame_piso.sv
// ============================================================================
//  Module      : led_frame_piso
//  Description : Parallel-load frame shift register, MSB-first serial output.
//                Zeros are shifted in behind the frame so the output idles low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_frame_piso #(
   parameter int FRAME_BITS = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic [FRAME_BITS-1:0] i_frame,
   output logic                  o_sout
);

   logic [FRAME_BITS-1:0] r_sreg;

   // Load has priority over shift; shifting drains the register to all zeros.
   always_ff @(posedge clk) begin
      if (reset)
         r_sreg <= '0;
      else if (i_load)
         r_sreg <= i_frame;
      else if (i_shift)
         r_sreg <= r_sreg << 1;
   end

   assign o_sout = r_sreg[FRAME_BITS-1];

endmodule

`default_nettype wire

// File: rtl/led_frame_loader.sv
// ============================================================================
//  Module      : led_frame_loader
//  Description : Collects NCOLS column bytes, shifts the frame out one bit per
//                clock (last column, top bit first) and pulses the latch strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_frame_loader
   import led_matrix_pkg::*;
#(
   parameter int NCOLS      = c_NCOLS_DEFAULT,
   parameter int NROWS      = c_NROWS_DEFAULT,
   parameter int STROBE_LEN = 1
) (
   input  logic               clk,
   input  logic               reset,
   led_frame_loader_if.slave  s_in,
   output logic               sdata,
   output logic               strobe,
   output logic               busy,
   output logic               frame_done
);

   localparam int c_FRAME_BITS = NCOLS * NROWS;
   localparam int c_CW = cnt_width(NCOLS);
   localparam int c_BW = cnt_width(c_FRAME_BITS);
   localparam int c_LW = cnt_width(STROBE_LEN);
   localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(NCOLS - 1);
   localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_FRAME_BITS - 1);
   localparam logic [c_LW-1:0] c_LAT_LAST = c_LW'(STROBE_LEN - 1);

   state_t                  r_state;
   state_t                  w_next;
   logic [c_CW-1:0]         r_col_cnt;
   logic [c_BW-1:0]         r_bit_cnt;
   logic [c_LW-1:0]         r_lat_cnt;
   logic [NROWS-1:0]        r_staging [NCOLS];
   logic [c_CW-1:0]         w_wr_col;
   logic [c_FRAME_BITS-1:0] w_frame;
   logic                    w_accept;
   logic                    w_last_col;
   logic                    w_load;
   logic                    w_shift;
   logic                    w_strobe_d;
   logic                    w_busy_d;
   logic                    w_done_d;

   assign s_in.in_ready = (r_state == FILL);
   assign w_accept      = s_in.in_valid & s_in.in_ready;
   assign w_wr_col      = s_in.in_sof ? '0 : r_col_cnt;
   assign w_last_col    = (w_wr_col == c_COL_LAST);

   // Frame image with the byte being accepted merged in, so the shifter can load on the completing edge.
   always_comb begin
      w_frame = '0;
      for (int c = 0; c < NCOLS; c++) begin
         w_frame[c*NROWS +: NROWS] = (w_accept && (w_wr_col == c_CW'(c))) ? s_in.in_data : r_staging[c];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= FILL;
      else
         r_state <= w_next;
   end

   // Next-state decode: full frame starts shifting, last bit starts latching, strobe end returns to fill.
   always_comb begin
      w_next = r_state;
      case (r_state)
         FILL:    if (w_accept && w_last_col)      w_next = SHIFT;
         SHIFT:   if (r_bit_cnt == c_BIT_LAST)     w_next = LATCH;
         LATCH:   if (r_lat_cnt == c_LAT_LAST)     w_next = FILL;
         default: w_next = FILL;
      endcase
   end

   // Output decode: shifter control and the next values of the registered outputs.
   always_comb begin
      w_load     = 1'b0;
      w_shift    = 1'b0;
      w_done_d   = 1'b0;
      w_strobe_d = (w_next == LATCH);
      w_busy_d   = (w_next != FILL);
      case (r_state)
         FILL:    w_load = w_accept && w_last_col;
         SHIFT: begin
            w_shift  = 1'b1;
            w_done_d = (w_next == LATCH) && (c_LAT_LAST == '0);
         end
         LATCH:   w_done_d = (w_next == LATCH) && ((r_lat_cnt + 1'b1) == c_LAT_LAST);
         default: w_load = 1'b0;
      endcase
   end

   // Column, bit and strobe-length counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col_cnt <= '0;
         r_bit_cnt <= '0;
         r_lat_cnt <= '0;
      end else begin
         if (w_accept)
            r_col_cnt <= w_last_col ? '0 : w_wr_col + 1'b1;
         r_bit_cnt <= (r_state == SHIFT) ? r_bit_cnt + 1'b1 : '0;
         r_lat_cnt <= (r_state == LATCH) ? r_lat_cnt + 1'b1 : '0;
      end
   end

   // Staging store; contents need no reset since a frame is only emitted once every column is rewritten.
   always_ff @(posedge clk) begin
      if (w_accept)
         r_staging[w_wr_col] <= s_in.in_data;
   end

   // Registered driver-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         strobe     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         strobe     <= w_strobe_d;
         busy       <= w_busy_d;
         frame_done <= w_done_d;
      end
   end

   led_frame_piso #(
      .FRAME_BITS (c_FRAME_BITS)
   ) u_piso (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_frame (w_frame),
      .o_sout  (sdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_led_frame_loader.sv
// ============================================================================
//  Module      : tb_led_frame_loader
//  Description : Self-checking bench; two loaders (strobe length 1 and 3) fed
//                from one byte list, checked against a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_led_frame_loader;
   import led_matrix_pkg::*;

   localparam int NC  = 8;
   localparam int NR  = 8;
   localparam int FB  = NC * NR;
   localparam int SL0 = 1;
   localparam int SL1 = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   led_frame_loader_if #(.NROWS(NR)) if0 ();
   led_frame_loader_if #(.NROWS(NR)) if1 ();

   logic [NR-1:0] d_data [2];
   logic [1:0]    d_valid;
   logic [1:0]    d_sof;
   wire  [1:0]    w_sd, w_str, w_busy, w_done, w_rdy;

   assign if0.in_data  = d_data[0];
   assign if0.in_valid = d_valid[0];
   assign if0.in_sof   = d_sof[0];
   assign if1.in_data  = d_data[1];
   assign if1.in_valid = d_valid[1];
   assign if1.in_sof   = d_sof[1];
   assign w_rdy        = {if1.in_ready, if0.in_ready};

   led_frame_loader #(.NCOLS(NC), .NROWS(NR), .STROBE_LEN(SL0)) u_dut0 (
      .clk(clk), .reset(reset), .s_in(if0),
      .sdata(w_sd[0]), .strobe(w_str[0]), .busy(w_busy[0]), .frame_done(w_done[0]));

   led_frame_loader #(.NCOLS(NC), .NROWS(NR), .STROBE_LEN(SL1)) u_dut1 (
      .clk(clk), .reset(reset), .s_in(if1),
      .sdata(w_sd[1]), .strobe(w_str[1]), .busy(w_busy[1]), .frame_done(w_done[1]));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Shared byte list {sof, data}; each source walks it at its own pace.
   logic [NR:0] stim [$];
   int          idx [2] = '{0, 0};
   bit          hold = 1'b0;

   // Model: staging bytes, next column, and t = cycles into the output timeline (0 = filling).
   logic [NR-1:0] m_stage [2][NC];
   int            m_col [2] = '{0, 0};
   int            m_t   [2] = '{0, 0};
   logic [FB-1:0] m_frame [2];
   bit            m_acc [2];
   bit            rst_hit [2];
   int            acc_cyc [2];

   // Driver-side model and run measurements.
   logic [FB-1:0] chain [2];
   logic [FB-1:0] vbuf  [2];
   bit            prev_str [2] = '{1'b0, 1'b0};
   int            rises [2] = '{0, 0};
   int            lat [2], str_run [2], last_run [2], done_pos [2];
   int            rdy_low [2] = '{0, 0};
   int            gap [2] = '{0, 0};
   bit            gap_arm [2] = '{1'b0, 1'b0};
   bit            t6_armed [2] = '{1'b0, 1'b0};
   bit            t6_mode = 1'b0;

   function automatic int slv(input int k);
      return (k == 0) ? SL0 : SL1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic model_step(input int k);
      int c;
      m_acc[k]   = 1'b0;
      rst_hit[k] = reset;
      if (reset) begin
         m_t[k]   = 0;
         m_col[k] = 0;
      end else if (m_t[k] != 0) begin
         m_t[k] = (m_t[k] == FB + slv(k)) ? 0 : m_t[k] + 1;
      end else if (d_valid[k]) begin
         m_acc[k] = 1'b1;
         c = d_sof[k] ? 0 : m_col[k];
         m_stage[k][c] = d_data[k];
         if (c == NC - 1) begin
            for (int j = 0; j < NC; j++) m_frame[k][j*NR +: NR] = m_stage[k][j];
            m_t[k]     = 1;
            m_col[k]   = 0;
            acc_cyc[k] = cyc - 1;
         end else begin
            m_col[k] = c + 1;
         end
      end
   endtask

   task automatic check_cycle(input int k);
      int t;
      int s;
      t = m_t[k];
      s = slv(k);
      chk($sformatf("u%0d in_ready", k), 64'(w_rdy[k]), 64'(t == 0));
      chk($sformatf("u%0d busy", k), 64'(w_busy[k]), 64'(t != 0));
      chk($sformatf("u%0d sdata", k), 64'(w_sd[k]), (t >= 1 && t <= FB) ? 64'(m_frame[k][FB-t]) : 64'd0);
      chk($sformatf("u%0d strobe", k), 64'(w_str[k]), 64'(t > FB));
      chk($sformatf("u%0d frame_done", k), 64'(w_done[k]), 64'(t == FB + s));

      if (w_busy[k] && !w_str[k]) chain[k] = {chain[k][FB-2:0], w_sd[k]};
      if (w_str[k] && !prev_str[k]) begin
         vbuf[k] = chain[k];
         rises[k]++;
         lat[k] = cyc - acc_cyc[k];
         chk($sformatf("u%0d vbuf", k), vbuf[k], m_frame[k]);
         chk($sformatf("u%0d strobe latency", k), 64'(lat[k]), 64'(FB + 1));
         if (t6_mode && !t6_armed[k]) begin
            t6_armed[k] = 1'b1;
            gap_arm[k]  = 1'b1;
            gap[k]      = 0;
         end
      end

      if (rst_hit[k]) begin
         str_run[k] = 0;
         rdy_low[k] = 0;
      end else begin
         if (w_str[k]) begin
            str_run[k]++;
         end else if (prev_str[k]) begin
            last_run[k] = str_run[k];
            chk($sformatf("u%0d strobe width", k), 64'(str_run[k]), 64'(s));
            str_run[k] = 0;
         end
         if (w_done[k]) done_pos[k] = str_run[k];
         if (!w_rdy[k]) begin
            rdy_low[k]++;
         end else if (rdy_low[k] > 0) begin
            chk($sformatf("u%0d ready low run", k), 64'(rdy_low[k]), 64'(FB + s));
            rdy_low[k] = 0;
         end
      end

      if (!w_busy[k]) begin
         gap[k]++;
      end else begin
         if (gap_arm[k] && gap[k] > 0) begin
            chk($sformatf("u%0d busy gap", k), 64'(gap[k]), 64'(NC));
            gap_arm[k] = 1'b0;
         end
         gap[k] = 0;
      end
      prev_str[k] = w_str[k];
   endtask

   // Model update on each edge, DUT comparison just after it.
   initial begin : p_check
      forever begin
         @(posedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) model_step(k);
         #1;
         for (int k = 0; k < 2; k++) check_cycle(k);
      end
   end

   // Sources: present the next list byte, hold it until accepted.
   initial begin : p_drive
      d_valid   = 2'b00;
      d_sof     = 2'b00;
      d_data[0] = '0;
      d_data[1] = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (m_acc[k]) begin
               idx[k]++;
               d_valid[k] = 1'b0;
            end
            if (!d_valid[k] && idx[k] < stim.size() && (hold || $urandom_range(0, 3) != 0)) begin
               d_valid[k] = 1'b1;
               {d_sof[k], d_data[k]} = stim[idx[k]];
            end else if (!d_valid[k]) begin
               d_sof[k]  = 1'($urandom);
               d_data[k] = NR'($urandom);
            end
         end
      end
   end

   task automatic push(input logic sof, input logic [NR-1:0] d);
      stim.push_back({sof, d});
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int  n;
      bit  ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk);
         n++;
         ok = (idx[0] == stim.size()) && (idx[1] == stim.size()) && (m_t[0] == 0) && (m_t[1] == 0);
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: timeout after %0d cycles", nm, n);
      end
   endtask

   initial begin : p_main
      int            base;
      int            r0 [2];
      int            n;
      logic [FB-1:0] expf;
      logic [FB-1:0] saved;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset in_ready", 64'(w_rdy), 64'd3);
      chk("reset busy", 64'(w_busy), 64'd0);
      chk("reset strobe", 64'(w_str), 64'd0);
      chk("reset sdata", 64'(w_sd), 64'd0);
      chk("reset frame_done", 64'(w_done), 64'd0);

      // T1: bytes 1..8
      for (int c = 0; c < NC; c++) push(c == 0, NR'(c + 1));
      wait_idle(400, "T1");
      chk("T1 model frame", m_frame[0], 64'h0807060504030201);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("T1 u%0d vbuf", k), vbuf[k], 64'h0807060504030201);
         chk($sformatf("T1 u%0d latency", k), 64'(lat[k]), 64'd65);
      end

      // T2: valid held high, three frames back to back
      hold = 1'b1;
      base = stim.size();
      r0   = rises;
      for (int i = 0; i < 3 * NC; i++) push((i % NC) == 0, NR'($urandom));
      wait_idle(900, "T2");
      for (int c = 0; c < NC; c++) expf[c*NR +: NR] = stim[base + 2*NC + c][NR-1:0];
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("T2 u%0d frames", k), 64'(rises[k] - r0[k]), 64'd3);
         chk($sformatf("T2 u%0d last vbuf", k), vbuf[k], expf);
      end
      hold = 1'b0;

      // T3: sof restarts a partial frame
      push(1'b1, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33);
      push(1'b1, 8'hAA);
      for (int c = 1; c < NC; c++) push(1'b0, NR'(8'hB0 + c));
      wait_idle(400, "T3");
      for (int k = 0; k < 2; k++)
         chk($sformatf("T3 u%0d vbuf", k), vbuf[k], 64'hB7B6B5B4B3B2B1AA);

      // Randomized frames with sporadic sof
      for (int i = 0; i < 6 * NC; i++) push((i % NC) == 0 || $urandom_range(0, 9) == 0, NR'($urandom));
      wait_idle(2500, "random");

      // T4: reset during shift bit 30
      for (int c = 0; c < NC; c++) push(c == 0, NR'($urandom));
      n = 0;
      while (m_t[0] != 31 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (m_t[0] != 31) begin
         total++;
         bad++;
         $display("FAIL T4 wait: shift bit 30 not reached in %0d cycles", n);
      end
      saved = vbuf[0];
      r0    = rises;
      reset = 1'b1;
      @(posedge clk);
      #2;
      chk("T4 sdata", 64'(w_sd[0]), 64'd0);
      chk("T4 strobe", 64'(w_str[0]), 64'd0);
      chk("T4 busy", 64'(w_busy[0]), 64'd0);
      chk("T4 in_ready", 64'(w_rdy[0]), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("T4 no strobe", 64'(rises[0]), 64'(r0[0]));
      chk("T4 vbuf kept", vbuf[0], saved);
      wait_idle(400, "T4 drain");

      // T5: strobe width and done position
      for (int c = 0; c < NC; c++) push(c == 0, NR'($urandom));
      wait_idle(400, "T5");
      chk("T5 u1 strobe width", 64'(last_run[1]), 64'd3);
      chk("T5 u1 done position", 64'(done_pos[1]), 64'd3);
      chk("T5 u0 done position", 64'(done_pos[0]), 64'd1);

      // T6: all-ones then all-zeros frames back to back
      hold    = 1'b1;
      t6_mode = 1'b1;
      r0      = rises;
      for (int c = 0; c < NC; c++) push(c == 0, '1);
      for (int c = 0; c < NC; c++) push(c == 0, '0);
      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (rises[k] == r0[k] && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("T6 u%0d vbuf ones", k), vbuf[k], '1);
      end
      wait_idle(600, "T6");
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("T6 u%0d vbuf zeros", k), vbuf[k], '0);
         chk($sformatf("T6 u%0d gap measured", k), 64'(gap_arm[k]), 64'd0);
      end
      hold = 1'b0;

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
